// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: fetch/decode/execute/memory/writeback FSM with ack timeouts.
// Optional feature: define RETIRE_CNT_EN to build the retired-instruction counter.
module multicycle_sequencer #(
   parameter int ACK_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op_in,
   input  logic       imem_ack,
   input  logic       dmem_ack,
   input  logic       zero,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic       jal,
   output logic [1:0] alu_op,
   output logic [3:0] state,
   output logic       halted,
   output logic       fault,
   output logic [15:0] retire_cnt
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_MEM    = 4'd3,
      S_WB     = 4'd4,
      S_BRANCH = 4'd5,
      S_JUMP   = 4'd6,
      S_HALT   = 4'd7,
      S_FAULT  = 4'd8
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   // Counter value during the last wait cycle we are allowed before faulting.
   localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [5:0] opcode_q, opcode_d;
   logic [7:0] wait_q, wait_d;
   logic       wait_expired;

   function automatic logic is_alu_class(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
   endfunction

   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      return is_alu_class(op) || (op == OP_BEQ) || (op == OP_J) ||
             (op == OP_JAL) || (op == OP_HALT);
   endfunction

   assign wait_expired = (wait_q == WAIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_FETCH;
         opcode_q <= '0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         wait_q   <= wait_d;
      end
   end

   // Wait counter only survives while stalled in FETCH/MEM; every other path clears it.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      wait_d   = '0;
      case (state_q)
         S_FETCH: begin
            if (imem_ack) begin
               state_d  = S_DECODE;
               opcode_d = op_in;
            end else if (wait_expired) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            if (is_alu_class(opcode_q))                     state_d = S_EXEC;
            else if (opcode_q == OP_BEQ)                    state_d = S_BRANCH;
            else if ((opcode_q == OP_J) || (opcode_q == OP_JAL)) state_d = S_JUMP;
            else if (opcode_q == OP_HALT)                   state_d = S_HALT;
            else                                            state_d = S_FETCH;
         end
         S_EXEC: begin
            state_d = is_mem_op(opcode_q) ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (dmem_ack) begin
               state_d = (opcode_q == OP_SW) ? S_FETCH : S_WB;
            end else if (wait_expired) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_HALT:                 state_d = S_HALT;
         S_FAULT:                state_d = S_FAULT;
         default:                state_d = S_FAULT;
      endcase
   end

   // Outputs are forced low while rst is held so nothing leaks during an abandoned instruction.
   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      reg_write = 1'b0;
      jal       = 1'b0;
      alu_op    = 2'b00;
      halted    = 1'b0;
      fault     = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_write = imem_ack;
            end
            S_DECODE: begin
               pc_write = !is_legal(opcode_q);
            end
            S_EXEC: begin
               alu_op = (opcode_q == OP_RTYPE) ? 2'b10 : 2'b00;
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (opcode_q == OP_SW);
               pc_write = dmem_ack && (opcode_q == OP_SW);
            end
            S_WB: begin
               reg_write = 1'b1;
               pc_write  = 1'b1;
            end
            S_BRANCH: begin
               alu_op   = 2'b01;
               pc_write = 1'b1;
               pc_src   = zero ? 2'b01 : 2'b00;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_src    = 2'b10;
               reg_write = (opcode_q == OP_JAL);
               jal       = (opcode_q == OP_JAL);
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: fault  = 1'b1;
         endcase
      end
   end

   assign state = state_q;

`ifdef RETIRE_CNT_EN
   logic [15:0] retire_q, retire_d;

   assign retire_d = pc_write ? retire_q + 16'd1 : retire_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) retire_q <= '0;
      else     retire_q <= retire_d;
   end

   assign retire_cnt = retire_q;
`else
   assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: instruction-level cycle model feeds an expected queue,
// a monitor compares every cycle's state/strobes/counter against it.
module tb_multicycle_sequencer;
   localparam int TMO = 8;
`ifdef RETIRE_CNT_EN
   localparam bit RCE = 1'b1;
`else
   localparam bit RCE = 1'b0;
`endif

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_HALT = 6'b111111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  op_in = '0;
   logic        imem_ack = 1'b0, dmem_ack = 1'b0, zero = 1'b0;
   logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write, jal, halted, fault;
   logic [1:0]  pc_src, alu_op;
   logic [3:0]  state;
   logic [15:0] retire_cnt;

   multicycle_sequencer #(.ACK_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .op_in(op_in), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .zero(zero), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
      .jal(jal), .alu_op(alu_op), .state(state), .halted(halted), .fault(fault),
      .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  st;
      logic        imreq, dmreq, we, irw, pcw;
      logic [1:0]  pcsrc;
      logic        rw, jl;
      logic [1:0]  aluop;
      logic        hlt, flt;
      logic [15:0] ret;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_ret   = 0;
   bit   stim_done = 1'b0;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom);
   endfunction

   function automatic bit legal(input logic [5:0] op);
      return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_HALT};
   endfunction

   function automatic exp_t base(input logic [3:0] s);
      exp_t e;
      e     = '0;
      e.st  = s;
      e.hlt = (s == 4'd7);
      e.flt = (s == 4'd8);
      e.ret = RCE ? 16'(m_ret) : 16'd0;
      return e;
   endfunction

   // One clock of stimulus plus the response the model expects during that clock.
   task automatic cyc(input logic r, input logic ia, input logic da, input logic z,
                      input logic [5:0] op, input exp_t e);
      @(posedge clk);
      #1;
      rst = r; imem_ack = ia; dmem_ack = da; zero = z; op_in = op;
      exp_q.push_back(e);
      if (e.pcw) m_ret = (m_ret + 1) & 16'hFFFF;
   endtask

   task automatic do_reset(input int n);
      m_ret = 0;
      repeat (n) cyc(1'b1, rb(), rb(), rb(), r6(), base(4'd0));
   endtask

   task automatic hold(input logic [3:0] s, input int n);
      repeat (n) cyc(1'b0, rb(), rb(), rb(), r6(), base(s));
   endtask

   // abort_at >= 0 pulses reset after that many MEM cycles.
   task automatic do_instr(input logic [5:0] op, input int fwait, input int mwait,
                           input logic z, input int abort_at);
      exp_t e;
      for (int i = 0; i < fwait && i < TMO; i++) begin
         e = base(4'd0); e.imreq = 1'b1;
         cyc(1'b0, 1'b0, rb(), rb(), r6(), e);
      end
      if (fwait >= TMO) begin
         hold(4'd8, 6);
         do_reset(2);
         return;
      end
      e = base(4'd0); e.imreq = 1'b1; e.irw = 1'b1;
      cyc(1'b0, 1'b1, rb(), rb(), op, e);
      e = base(4'd1); e.pcw = !legal(op);
      cyc(1'b0, rb(), rb(), rb(), r6(), e);
      if (!legal(op)) return;
      if (op == OP_HALT) begin
         hold(4'd7, 20);
         do_reset(2);
         return;
      end
      if (op == OP_BEQ) begin
         e = base(4'd5); e.aluop = 2'd1; e.pcw = 1'b1; e.pcsrc = z ? 2'd1 : 2'd0;
         cyc(1'b0, rb(), rb(), z, r6(), e);
         return;
      end
      if (op == OP_J || op == OP_JAL) begin
         e = base(4'd6); e.pcw = 1'b1; e.pcsrc = 2'd2;
         e.rw = (op == OP_JAL); e.jl = (op == OP_JAL);
         cyc(1'b0, rb(), rb(), rb(), r6(), e);
         return;
      end
      e = base(4'd2); e.aluop = (op == OP_R) ? 2'd2 : 2'd0;
      cyc(1'b0, rb(), rb(), rb(), r6(), e);
      if (op == OP_LW || op == OP_SW) begin
         for (int i = 0; i < mwait && i < TMO; i++) begin
            if (i == abort_at) begin
               do_reset(2);
               return;
            end
            e = base(4'd3); e.dmreq = 1'b1; e.we = (op == OP_SW);
            cyc(1'b0, rb(), 1'b0, rb(), r6(), e);
         end
         if (mwait >= TMO) begin
            hold(4'd8, 6);
            do_reset(2);
            return;
         end
         e = base(4'd3); e.dmreq = 1'b1; e.we = (op == OP_SW); e.pcw = (op == OP_SW);
         cyc(1'b0, rb(), 1'b1, rb(), r6(), e);
         if (op == OP_SW) return;
      end
      e = base(4'd4); e.rw = 1'b1; e.pcw = 1'b1;
      cyc(1'b0, rb(), rb(), rb(), r6(), e);
   endtask

   function automatic int pick_wait();
      if ($urandom_range(0, 9) == 0) return int'($urandom_range(TMO - 1, TMO));
      return int'($urandom_range(0, 3));
   endfunction

   initial begin : stim
      logic [5:0] op;
      int k, ab;
      do_reset(3);
      do_instr(OP_R,    0, 0, 1'b0, -1);
      do_instr(OP_LW,   0, 3, 1'b0, -1);
      do_instr(OP_BEQ,  0, 0, 1'b1, -1);
      do_instr(OP_BEQ,  0, 0, 1'b0, -1);
      do_instr(OP_SW,   1, 2, 1'b0, -1);
      do_instr(OP_ADDI, 2, 0, 1'b0, -1);
      do_instr(OP_J,    0, 0, 1'b0, -1);
      do_instr(OP_JAL,  0, 0, 1'b0, -1);
      do_instr(6'b000001, 0, 0, 1'b0, -1);
      do_instr(OP_R,    TMO - 1, 0, 1'b0, -1);
      do_instr(OP_LW,   0, TMO - 1, 1'b0, -1);
      do_instr(OP_SW,   0, TMO - 1, 1'b0, -1);
      do_instr(OP_LW,   0, 10, 1'b0, 2);
      do_instr(OP_R,    TMO, 0, 1'b0, -1);
      do_instr(OP_SW,   0, TMO, 1'b0, -1);
      do_instr(OP_HALT, 0, 0, 1'b0, -1);
      for (int n = 0; n < 250; n++) begin
         k = int'($urandom_range(0, 19));
         case (k)
            0, 1, 2, 18, 19: op = OP_R;
            3, 4:            op = OP_ADDI;
            5, 6, 7:         op = OP_LW;
            8, 9, 10:        op = OP_SW;
            11, 12, 13:      op = OP_BEQ;
            14:              op = OP_J;
            15:              op = OP_JAL;
            17:              op = OP_HALT;
            default: begin
               op = r6();
               while (legal(op)) op = r6();
            end
         endcase
         ab = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 1)) : -1;
         do_instr(op, pick_wait(), pick_wait(), rb(), ab);
      end
      stim_done = 1'b1;
   end

   initial begin : monitor
      exp_t got, exp;
      int   cyc_n;
      cyc_n = 0;
      forever begin
         @(negedge clk);
         cyc_n++;
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {state, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
                   reg_write, jal, alu_op, halted, fault, retire_cnt};
            n_tests++;
            if (got !== exp) begin
               n_fail++;
               $display("FAIL cycle %0d: got st=%0d sig=%b ret=%0d, expected st=%0d sig=%b ret=%0d",
                        cyc_n, got.st, got[28:16], got.ret, exp.st, exp[28:16], exp.ret);
            end
         end else if (stim_done) begin
            break;
         end
         if (cyc_n > 60000) begin
            n_fail++;
            $display("FAIL watchdog: %0d cycles elapsed, %0d expectations pending", cyc_n, exp_q.size());
            break;
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
